// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one byte-wide data memory port between the core
// (port C) and the debug/loader (port D). Each granted request is serialized
// into 1, 2 or 4 byte cycles, little-endian, with sign/zero extension of loads.
//
// Optional build macro DM_ALIGN_CHECK_EN: when defined, misaligned half/word
// accesses are rejected through the error path instead of being sequenced.
//
// state | meaning
// IDLE  | arbitrate between pending requests, latch the winner, check validity
// XFER  | one memory byte per cycle, idx = 0 .. N-1
// DONE  | ack/err/rdata of the granted port are presented for one cycle

module data_mem_arbiter #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_wr,
   input  logic [2:0]        c_ctrl,
   input  logic [31:0]       c_addr,
   input  logic [31:0]       c_wdata,
   output logic              c_ack,
   output logic              c_err,
   output logic [31:0]       c_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [2:0]        d_ctrl,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [31:0]       d_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t              state_q;
   logic                last_q;        // 1 = D granted last
   logic                port_q;        // 1 = D owns the current transfer
   logic                wr_q;
   logic [2:0]          ctrl_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [1:0]          idx_q;
   logic [1:0]          idx_last_q;
   logic [31:0]         buf_q;
   logic                c_ack_q, c_err_q, d_ack_q, d_err_q;
   logic [31:0]         c_rdata_q, d_rdata_q;

   logic                sel_d;
   logic                any_req;
   logic                req_wr;
   logic [2:0]          req_ctrl;
   logic [31:0]         req_addr;
   logic [31:0]         req_wdata;
   logic [2:0]          req_n;
   logic                req_bad;
   logic                misalign;
   logic [31:0]         buf_d;

   function automatic logic [2:0] byte_count(input logic [2:0] ctrl);
      case (ctrl)
         3'b010:         byte_count = 3'd4;
         3'b001, 3'b101: byte_count = 3'd2;
         default:        byte_count = 3'd1;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [31:0] w);
      case (ctrl)
         3'b000:  extend = {{24{w[7]}}, w[7:0]};
         3'b001:  extend = {{16{w[15]}}, w[15:0]};
         3'b100:  extend = {24'd0, w[7:0]};
         3'b101:  extend = {16'd0, w[15:0]};
         default: extend = w;
      endcase
   endfunction

   // Round-robin selection of the requester and validity check of its request.
   always_comb begin
      any_req = c_req | d_req;
      if (c_req && d_req) sel_d = ~last_q;
      else                sel_d = d_req;
      req_wr    = sel_d ? d_wr    : c_wr;
      req_ctrl  = sel_d ? d_ctrl  : c_ctrl;
      req_addr  = sel_d ? d_addr  : c_addr;
      req_wdata = sel_d ? d_wdata : c_wdata;
      req_n     = byte_count(req_ctrl);
`ifdef DM_ALIGN_CHECK_EN
      misalign  = ((req_ctrl[1:0] == 2'b01) && req_addr[0])
               || ((req_ctrl == 3'b010) && (req_addr[1:0] != 2'b00));
`else
      misalign  = 1'b0;
`endif
      // Range check in 33 bits so addresses near 2**32 cannot wrap into range.
      req_bad   = (req_ctrl == 3'b011) || (req_ctrl == 3'b110) || (req_ctrl == 3'b111)
               || (req_ctrl[2] && req_wr)
               || (({1'b0, req_addr} + 33'(req_n)) > 33'(DEPTH))
               || misalign;
   end

   // Load buffer with the current memory byte merged into lane idx.
   always_comb begin
      buf_d = buf_q;
      buf_d[{idx_q, 3'b000} +: 8] = mem_rdata;
   end

   // Memory port is driven only while transferring; zero otherwise.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = 8'd0;
      if (state_q == XFER) begin
         mem_addr = addr_q + ADDR_W'(idx_q);
         mem_we   = wr_q;
         if (wr_q) mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
      end
   end

   // Sequencer: arbitration, byte sequencing and registered port responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         port_q     <= 1'b0;
         wr_q       <= 1'b0;
         ctrl_q     <= 3'd0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         idx_q      <= 2'd0;
         idx_last_q <= 2'd0;
         buf_q      <= 32'd0;
         c_ack_q    <= 1'b0;
         c_err_q    <= 1'b0;
         c_rdata_q  <= 32'd0;
         d_ack_q    <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= 32'd0;
      end else begin
         c_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  last_q     <= sel_d;
                  port_q     <= sel_d;
                  wr_q       <= req_wr;
                  ctrl_q     <= req_ctrl;
                  addr_q     <= req_addr[ADDR_W-1:0];
                  wdata_q    <= req_wdata;
                  idx_q      <= 2'd0;
                  idx_last_q <= 2'(req_n - 3'd1);
                  buf_q      <= 32'd0;
                  if (req_bad) begin
                     state_q <= DONE;
                     if (sel_d) begin
                        d_ack_q   <= 1'b1;
                        d_err_q   <= 1'b1;
                        d_rdata_q <= 32'd0;
                     end else begin
                        c_ack_q   <= 1'b1;
                        c_err_q   <= 1'b1;
                        c_rdata_q <= 32'd0;
                     end
                  end else begin
                     state_q <= XFER;
                  end
               end
            end
            XFER: begin
               if (!wr_q) buf_q <= buf_d;
               idx_q <= idx_q + 2'd1;
               if (idx_q == idx_last_q) begin
                  state_q <= DONE;
                  if (port_q) begin
                     d_ack_q <= 1'b1;
                     d_err_q <= 1'b0;
                     if (!wr_q) d_rdata_q <= extend(ctrl_q, buf_d);
                  end else begin
                     c_ack_q <= 1'b1;
                     c_err_q <= 1'b0;
                     if (!wr_q) c_rdata_q <= extend(ctrl_q, buf_d);
                  end
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = (state_q != IDLE);
   assign c_ack   = c_ack_q;
   assign c_err   = c_err_q;
   assign c_rdata = c_rdata_q;
   assign d_ack   = d_ack_q;
   assign d_err   = d_err_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes the expected ack
// (port, err, rdata, cycle) and expected byte writes; monitors pop and compare.

module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req, c_wr, d_req, d_wr;
   logic [2:0]  c_ctrl, d_ctrl;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic        c_ack, c_err, d_ack, d_err, busy;
   logic [31:0] c_rdata, d_rdata;
   logic [5:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata, mem_rdata;

   logic [7:0]  mem [0:63];
   logic        poke_en = 1'b0;
   logic [5:0]  poke_a = 6'd0;
   logic [7:0]  poke_d = 8'd0;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct { bit port; bit err; logic [31:0] rdata; int cyc; } exp_t;
   typedef struct { logic [5:0] a; logic [7:0] d; } wexp_t;
   exp_t  exp_q[$];
   wexp_t wexp_q[$];

   data_mem_arbiter #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_wr(c_wr), .c_ctrl(c_ctrl), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_ctrl(d_ctrl), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (poke_en)     mem[poke_a]   <= poke_d;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Ack monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && (c_ack || d_ack)) begin
         if (c_ack && d_ack) begin
            checks++; errors++;
            $display("FAIL dual_ack: both ports acked at cycle %0d", cyc);
         end
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: c_ack=%0b d_ack=%0b at cycle %0d", c_ack, d_ack, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ack_port", {31'd0, d_ack}, {31'd0, e.port});
            check("ack_err", {31'd0, d_ack ? d_err : c_err}, {31'd0, e.err});
            check("ack_rdata", d_ack ? d_rdata : c_rdata, e.rdata);
            check("ack_cycle", cyc, e.cyc);
         end
      end
   end

   // Write monitor: every byte strobe must match the next expected write.
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         if (wexp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %h data %h at cycle %0d", mem_addr, mem_wdata, cyc);
         end else begin
            wexp_t w;
            w = wexp_q.pop_front();
            check("wr_addr", {26'd0, mem_addr}, {26'd0, w.a});
            check("wr_data", {24'd0, mem_wdata}, {24'd0, w.d});
         end
      end
   end

   task automatic poke(input logic [5:0] a, input logic [7:0] d);
      poke_a = a; poke_d = d; poke_en = 1'b1;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Drive one request (caller is just after a rising edge: that is cycle 0).
   task automatic issue(input bit p, input bit wr, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit e_err, input logic [31:0] e_rd, input int lat, input int nw);
      if (p) begin
         d_req = 1'b1; d_wr = wr; d_ctrl = ctrl; d_addr = addr; d_wdata = wdata;
      end else begin
         c_req = 1'b1; c_wr = wr; c_ctrl = ctrl; c_addr = addr; c_wdata = wdata;
      end
      if (lat > 0) exp_q.push_back('{port: p, err: e_err, rdata: e_rd, cyc: cyc + lat});
      for (int i = 0; i < nw; i++)
         wexp_q.push_back('{a: 6'(addr[5:0] + 6'(i)), d: wdata[8*i +: 8]});
   endtask

   // Wait for the wanted acks, dropping each req in the cycle after its ack.
   task automatic wait_done(input bit want_c, input bit want_d);
      bit got_c, got_d, now_c, now_d;
      int n;
      got_c = !want_c; got_d = !want_d; n = 0;
      while (!(got_c && got_d) && n < 40) begin
         @(negedge clk);
         now_c = c_ack; now_d = d_ack;
         n++;
         @(posedge clk); #1;
         if (now_c) begin got_c = 1'b1; c_req = 1'b0; end
         if (now_d) begin got_d = 1'b1; d_req = 1'b0; end
      end
      if (!(got_c && got_d)) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got_c=%0b got_d=%0b after %0d cycles", got_c, got_d, n);
         c_req = 1'b0; d_req = 1'b0;
      end
   endtask

   task automatic op(input bit p, input bit wr, input logic [2:0] ctrl,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input bit e_err, input logic [31:0] e_rd, input int lat, input int nw);
      @(posedge clk); #1;
      issue(p, wr, ctrl, addr, wdata, e_err, e_rd, lat, nw);
      wait_done(!p, p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      c_req = 0; c_wr = 0; c_ctrl = 0; c_addr = 0; c_wdata = 0;
      d_req = 0; d_wr = 0; d_ctrl = 0; d_addr = 0; d_wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_flags", {26'd0, c_ack, d_ack, c_err, d_err, busy, mem_we}, 32'd0);
      check("rst_c_rdata", c_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_mem_port", {18'd0, mem_addr, mem_wdata}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Word store, then byte/half/word loads with sign and zero extension.
      op(0, 1, 3'b010, 32'd8, 32'hA1B2C3D4, 0, 32'h0, 5, 4);
      poke(6'd8, 8'h80);
      op(0, 0, 3'b000, 32'd8, 32'h0, 0, 32'hFFFFFF80, 2, 0);
      op(0, 0, 3'b100, 32'd8, 32'h0, 0, 32'h00000080, 2, 0);
      poke(6'd10, 8'h34);
      poke(6'd11, 8'hF2);
      op(0, 0, 3'b001, 32'd10, 32'h0, 0, 32'hFFFFF234, 3, 0);
      op(0, 0, 3'b101, 32'd10, 32'h0, 0, 32'h0000F234, 3, 0);
      poke(6'd9, 8'h5A);
      op(0, 0, 3'b010, 32'd8, 32'h0, 0, 32'hF2345A80, 5, 0);
      // A store leaves the previous load result in place.
      op(0, 1, 3'b000, 32'd5, 32'h00000077, 0, 32'hF2345A80, 2, 1);

      // Error path: ack in cycle 1, err set, rdata cleared, no writes.
      op(0, 1, 3'b010, 32'd62, 32'h12345678, 1, 32'h0, 1, 0);
      op(0, 0, 3'b011, 32'd0, 32'h0, 1, 32'h0, 1, 0);
      op(0, 1, 3'b101, 32'd0, 32'h0000ABCD, 1, 32'h0, 1, 0);
      op(0, 0, 3'b000, 32'h00000100, 32'h0, 1, 32'h0, 1, 0);
      op(0, 0, 3'b010, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1, 0);
      poke(6'd6, 8'h11);
      poke(6'd7, 8'h22);
`ifdef DM_ALIGN_CHECK_EN
      op(0, 0, 3'b010, 32'd6, 32'h0, 1, 32'h0, 1, 0);
`else
      op(0, 0, 3'b010, 32'd6, 32'h0, 0, 32'h5A802211, 5, 0);
`endif

      // Port D stores at the top of memory (last legal byte and half).
      op(1, 1, 3'b000, 32'd63, 32'h000000C7, 0, 32'h0, 2, 1);
      op(1, 1, 3'b001, 32'd62, 32'h0000BEEF, 0, 32'h0, 3, 2);

      // Reset in the middle of a word store: bytes 0-1 land, no ack follows.
      for (int i = 0; i < 4; i++) poke(6'(i), 8'hEE);
      @(posedge clk); #1;
      issue(0, 1, 3'b010, 32'd0, 32'h11223344, 0, 32'h0, 0, 2);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      c_req = 1'b0;
      @(negedge clk);
      check("abort_flags", {29'd0, busy, mem_we, c_ack}, 32'd0);
      check("abort_mem_port", {18'd0, mem_addr, mem_wdata}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h4433EEEE);
      check("abort_writes_left", wexp_q.size(), 32'd0);

      // Simultaneous requests after reset: C first, D waits and is served next.
      @(posedge clk); #1;
      issue(0, 0, 3'b100, 32'd8, 32'h0, 0, 32'h00000080, 2, 0);
      issue(1, 0, 3'b000, 32'd11, 32'h0, 0, 32'hFFFFFFF2, 5, 0);
      wait_done(1, 1);
      // C was granted last after this single request, so the next pair goes to D first.
      op(0, 0, 3'b100, 32'd63, 32'h0, 0, 32'h000000BE, 2, 0);
      @(posedge clk); #1;
      issue(1, 0, 3'b100, 32'd62, 32'h0, 0, 32'h000000EF, 2, 0);
      issue(0, 0, 3'b000, 32'd9, 32'h0, 0, 32'h0000005A, 5, 0);
      wait_done(1, 1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("acks_left", exp_q.size(), 32'd0);
      check("writes_left", wexp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
